// File: rtl/req_ack_pkg.sv
// ---------------------------------------------------------------------------
// req_ack_pkg
// Shared types and default constants for the req/ack scheduler slice.
//   sched_state_e   : scheduler FSM states (IDLE, WAIT_ACK, COOLDOWN)
//   *_DEF           : default parameter values used by req_ack_scheduler
//   next_index()    : round-robin pointer advance with wrap at n
// ---------------------------------------------------------------------------
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_e;

    localparam int N_REQ_DEF       = 4;
    localparam int ACK_LATENCY_DEF = 4;
    localparam int MIN_GAP_DEF     = 8;

    // Index following idx in a ring of n entries.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after the pointer, wrapping around the ring of N_REQ clients.
//   req_vec : request vector, one bit per client
//   ptr     : index where the search starts (0..N_REQ-1)
//   grant   : one-hot winner (all zero when nobody requests)
//   idx     : binary index of the winner (0 when nobody requests)
//   any     : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_vec,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    // Walk the ring starting at the pointer; the first hit wins and every
    // later candidate is ignored because 'any' is already set.
    always_comb begin : arb_scan
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req_vec[cand_idx]) begin
                any             = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_ack_scheduler.sv
// ---------------------------------------------------------------------------
// req_ack_scheduler
// Shares one single-pulse req/ack resource among N_REQ clients. Clients are
// granted round-robin, each grant issues a one-cycle req, the ack is checked
// to land exactly ACK_LATENCY cycles later, and consecutive reqs are kept at
// least MIN_GAP cycles apart. All outputs are registered.
//   clk, rst         : clock, synchronous active-high reset
//   client_req       : level request per client, held until granted
//   client_grant     : one-hot grant pulse, coincident with req
//   done_valid/id/ok : one-cycle transaction result for the granted client
//   hold             : blocks new reqs (sampled in IDLE only)
//   req, ack         : resource handshake
//   busy             : scheduler not in IDLE
//   err_missing_ack  : sticky, an expected ack did not arrive
//   err_spurious_ack : sticky, ack seen outside the expected cycle
//   reqs_issued      : wrapping count of req pulses
// ---------------------------------------------------------------------------
module req_ack_scheduler
    import req_ack_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int ACK_LATENCY = ACK_LATENCY_DEF,
    parameter int MIN_GAP     = MIN_GAP_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         client_req,
    output logic [N_REQ-1:0]         client_grant,
    output logic                     done_valid,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic                     done_ok,
    input  logic                     hold,
    output logic                     req,
    input  logic                     ack,
    output logic                     busy,
    output logic                     err_missing_ack,
    output logic                     err_spurious_ack,
    output logic [7:0]               reqs_issued
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam int MASK_W = $clog2(ACK_LATENCY + 1);

    // gap_cnt is loaded with MIN_GAP-1 in the req cycle, so the expected
    // ack cycle is the one where it has dropped by ACK_LATENCY.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0]  ACK_SLOT  = GAP_W'(MIN_GAP - 1 - ACK_LATENCY);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [MASK_W-1:0] MASK_LOAD = MASK_W'(ACK_LATENCY);
    localparam logic [MASK_W-1:0] MASK_ONE  = MASK_W'(1);

    // Elaboration-time parameter sanity.
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("req_ack_scheduler: N_REQ must be within 2..16");
    end
    if (ACK_LATENCY < 1 || MIN_GAP <= ACK_LATENCY) begin : g_bad_timing
        $error("req_ack_scheduler: need MIN_GAP > ACK_LATENCY >= 1");
    end

    sched_state_e      state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d, gap_dec;
    logic [MASK_W-1:0] mask_cnt, mask_cnt_d;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]  owner_id, owner_id_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              ack_slot;

    logic              req_d;
    logic [N_REQ-1:0]  grant_d;
    logic              done_valid_d;
    logic [IDX_W-1:0]  done_id_d;
    logic              done_ok_d;
    logic              busy_d;
    logic              err_missing_d;
    logic              err_spurious_d;
    logic [7:0]        reqs_issued_d;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_vec (client_req),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    // The single cycle in which ack is allowed, and the saturating
    // decrement shared by WAIT_ACK and COOLDOWN.
    assign ack_slot = (state_q == WAIT_ACK) && (gap_cnt == ACK_SLOT);
    assign gap_dec  = (gap_cnt != '0) ? gap_cnt - GAP_ONE : '0;

    // Next-state and next-output logic. Every register has a default so the
    // block stays latch-free; a case arm only overrides what it changes.
    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt;
        rr_ptr_d       = rr_ptr;
        owner_id_d     = owner_id;
        mask_cnt_d     = (mask_cnt != '0) ? mask_cnt - MASK_ONE : '0;
        req_d          = 1'b0;
        grant_d        = '0;
        done_valid_d   = 1'b0;
        done_id_d      = '0;
        done_ok_d      = 1'b0;
        err_missing_d  = err_missing_ack;
        err_spurious_d = err_spurious_ack;
        reqs_issued_d  = reqs_issued;

        case (state_q)
            IDLE: begin
                if (!hold && arb_any) begin
                    req_d         = 1'b1;
                    grant_d       = arb_grant;
                    owner_id_d    = arb_idx;
                    rr_ptr_d      = IDX_W'(next_index(int'(arb_idx), N_REQ));
                    gap_cnt_d     = GAP_LOAD;
                    reqs_issued_d = reqs_issued + 8'd1;
                    state_d       = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                gap_cnt_d = gap_dec;
                if (ack_slot) begin
                    done_valid_d = 1'b1;
                    done_id_d    = owner_id;
                    done_ok_d    = ack;
                    if (!ack) begin
                        err_missing_d = 1'b1;
                    end
                    // With a tight MIN_GAP there may be no cooldown left.
                    if (gap_cnt <= GAP_ONE) begin
                        state_d   = IDLE;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                gap_cnt_d = gap_dec;
                if (gap_cnt <= GAP_ONE) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                gap_cnt_d = '0;
            end
        endcase

        // Any ack outside the slot is spurious, except during the window
        // right after reset where an ack from before reset may still land.
        if (ack && !ack_slot && (mask_cnt == '0)) begin
            err_spurious_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset abandons any transaction, clears the
    // sticky errors and arms the post-reset ack mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            gap_cnt          <= '0;
            mask_cnt         <= MASK_LOAD;
            rr_ptr           <= '0;
            owner_id         <= '0;
            req              <= 1'b0;
            client_grant     <= '0;
            done_valid       <= 1'b0;
            done_id          <= '0;
            done_ok          <= 1'b0;
            busy             <= 1'b0;
            err_missing_ack  <= 1'b0;
            err_spurious_ack <= 1'b0;
            reqs_issued      <= '0;
        end else begin
            state_q          <= state_d;
            gap_cnt          <= gap_cnt_d;
            mask_cnt         <= mask_cnt_d;
            rr_ptr           <= rr_ptr_d;
            owner_id         <= owner_id_d;
            req              <= req_d;
            client_grant     <= grant_d;
            done_valid       <= done_valid_d;
            done_id          <= done_id_d;
            done_ok          <= done_ok_d;
            busy             <= busy_d;
            err_missing_ack  <= err_missing_d;
            err_spurious_ack <= err_spurious_d;
            reqs_issued      <= reqs_issued_d;
        end
    end

`ifdef FORMAL
    // Last non-zero grant, used to cover grants to two different clients.
    logic [N_REQ-1:0] last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= '0;
        end else if (client_grant != '0) begin
            last_grant <= client_grant;
        end
    end

    // Target protocol: req is a single-cycle pulse followed by at least
    // MIN_GAP-1 low cycles.
    a_req_single : assert property (@(posedge clk) disable iff (rst)
        req |=> !req);
    a_req_spacing : assert property (@(posedge clk) disable iff (rst)
        req |=> (!req) [*(MIN_GAP - 1)]);

    c_two_clients : cover property (@(posedge clk) disable iff (rst)
        (client_grant != '0) && (last_grant != '0) && (client_grant != last_grant));
    c_not_ok : cover property (@(posedge clk) disable iff (rst)
        done_valid && !done_ok);
`endif

endmodule

// File: tb/tb_req_ack_scheduler.sv
// ---------------------------------------------------------------------------
// tb_req_ack_scheduler
// Directed scenarios followed by randomized traffic. A timeline model (req
// cycle numbers and plain arithmetic on them) predicts every output each
// cycle; a few scenario points are also checked against fixed constants.
// ---------------------------------------------------------------------------
module tb_req_ack_scheduler;

    localparam int N = 4;
    localparam int A = 4;
    localparam int G = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           hold;
    logic           ack;
    logic [N-1:0]   client_req;
    logic [N-1:0]   client_grant;
    logic           done_valid;
    logic [1:0]     done_id;
    logic           done_ok;
    logic           req;
    logic           busy;
    logic           err_missing_ack;
    logic           err_spurious_ack;
    logic [7:0]     reqs_issued;

    int check_count = 0;
    int fail_count  = 0;
    int cyc         = 0;

    // Model of the scheduler timeline.
    bit m_have;
    int m_req_cyc, m_id, m_ptr, m_mask_end, m_cnt;
    bit m_miss, m_spur;
    bit e_req, e_dv, e_dok, e_busy;
    int e_grant, e_did;

    req_ack_scheduler #(
        .N_REQ       (N),
        .ACK_LATENCY (A),
        .MIN_GAP     (G)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .client_req       (client_req),
        .client_grant     (client_grant),
        .done_valid       (done_valid),
        .done_id          (done_id),
        .done_ok          (done_ok),
        .hold             (hold),
        .req              (req),
        .ack              (ack),
        .busy             (busy),
        .err_missing_ack  (err_missing_ack),
        .err_spurious_ack (err_spurious_ack),
        .reqs_issued      (reqs_issued)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h",
                     tag, cyc, observed, expected);
        end
    endtask

    // True when the cycle about to be driven is the expected ack cycle.
    function automatic bit ackDue();
        return m_have && (cyc == m_req_cyc + A);
    endfunction

    // Advance the timeline model by the cycle whose inputs are on the pins.
    task automatic modelStep();
        bit slot, idle;
        int pick;
        e_req   = 0;
        e_grant = 0;
        e_dv    = 0;
        e_did   = 0;
        e_dok   = 0;
        if (rst) begin
            m_have     = 0;
            m_ptr      = 0;
            m_miss     = 0;
            m_spur     = 0;
            m_cnt      = 0;
            m_mask_end = cyc + A;
            e_busy     = 0;
        end else begin
            slot = m_have && (cyc == m_req_cyc + A);
            idle = !m_have || (cyc >= m_req_cyc + G - 1);
            if (slot) begin
                e_dv  = 1;
                e_did = m_id;
                e_dok = ack;
                if (!ack) m_miss = 1;
            end
            if (ack && !slot && cyc > m_mask_end) m_spur = 1;
            if (idle && !hold && client_req != '0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && client_req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                end
                e_req     = 1;
                e_grant   = 1 << pick;
                m_id      = pick;
                m_ptr     = (pick + 1) % N;
                m_have    = 1;
                m_req_cyc = cyc + 1;
                m_cnt     = (m_cnt + 1) % 256;
            end
            e_busy = m_have && (cyc + 1 <= m_req_cyc + G - 2);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compareAll();
        checkOutput("req",          32'(req),              32'(e_req));
        checkOutput("grant",        32'(client_grant),     32'(e_grant));
        checkOutput("done_valid",   32'(done_valid),       32'(e_dv));
        checkOutput("done_id",      32'(done_id),          32'(e_did));
        checkOutput("done_ok",      32'(done_ok),          32'(e_dok));
        checkOutput("busy",         32'(busy),             32'(e_busy));
        checkOutput("err_missing",  32'(err_missing_ack),  32'(m_miss));
        checkOutput("err_spurious", 32'(err_spurious_ack), 32'(m_spur));
        checkOutput("reqs_issued",  32'(reqs_issued),      32'(m_cnt));
    endtask

    // Drive one cycle of inputs, step the model at the edge, check after it.
    task automatic applyStimulus(input logic r, input logic h,
                                 input logic [N-1:0] c, input logic a);
        @(negedge clk);
        rst        = r;
        hold       = h;
        client_req = c;
        ack        = a;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        cyc++;
    endtask

    task automatic resetDut();
        applyStimulus(1, 0, '0, 0);
        applyStimulus(1, 0, '0, 0);
    endtask

    int               n_g;
    int               g_cyc [8];
    logic [N-1:0]     g_val [8];
    logic [N-1:0]     cur;

    initial begin
        rst        = 1;
        hold       = 0;
        ack        = 0;
        client_req = '0;

        // Client 2 alone from reset.
        resetDut();
        applyStimulus(0, 0, 4'b0100, 0);
        checkOutput("s1_req", 32'(req), 32'd1);
        checkOutput("s1_grant", 32'(client_grant), 32'h4);
        for (int k = 1; k <= 4; k++) applyStimulus(0, 0, '0, 0);
        applyStimulus(0, 0, '0, 1);
        checkOutput("s1_dv", 32'(done_valid), 32'd1);
        checkOutput("s1_id", 32'(done_id), 32'd2);
        checkOutput("s1_ok", 32'(done_ok), 32'd1);
        for (int k = 6; k <= 8; k++) applyStimulus(0, 0, '0, 0);
        checkOutput("s1_busy_low", 32'(busy), 32'd0);

        // All clients requesting continuously with on-time acks.
        resetDut();
        n_g = 0;
        for (int k = 0; k <= 33; k++) begin
            applyStimulus(0, 0, 4'hF, ackDue());
            if (req && n_g < 8) begin
                g_val[n_g] = client_grant;
                g_cyc[n_g] = k + 1;
                n_g++;
            end
        end
        checkOutput("s2_ngrants", 32'(n_g), 32'd5);
        for (int j = 0; j < n_g && j < 5; j++) begin
            checkOutput("s2_grant", 32'(g_val[j]), 32'(1 << (j % 4)));
            checkOutput("s2_cycle", 32'(g_cyc[j]), 32'(1 + 8 * j));
        end
        checkOutput("s2_count", 32'(reqs_issued), 32'd5);
        checkOutput("s2_errs", 32'({err_missing_ack, err_spurious_ack}), 32'd0);

        // Client 1 never acked; its held request is re-granted on schedule.
        resetDut();
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(0, 0, 4'b0010, 0);
            if (k == 5) begin
                checkOutput("s3_dv", 32'(done_valid), 32'd1);
                checkOutput("s3_id", 32'(done_id), 32'd1);
                checkOutput("s3_ok", 32'(done_ok), 32'd0);
                checkOutput("s3_miss", 32'(err_missing_ack), 32'd1);
            end
        end
        checkOutput("s3_regrant", 32'(client_grant), 32'h2);

        // Early ack and an ack in IDLE, after the post-reset mask window.
        resetDut();
        for (int k = 0; k <= 17; k++) begin
            applyStimulus(0, 0, (k == 4) ? 4'b0001 : 4'b0000,
                          (k == 7) || (k == 9) || (k == 16));
            if (k == 7) checkOutput("s4_spur", 32'(err_spurious_ack), 32'd1);
            if (k == 9) begin
                checkOutput("s4_dv", 32'(done_valid), 32'd1);
                checkOutput("s4_ok", 32'(done_ok), 32'd1);
            end
        end

        // hold blocks issue; raising it mid-transaction does not abort.
        resetDut();
        for (int k = 0; k <= 14; k++) begin
            applyStimulus(0, (k <= 5) || (k >= 8), (k <= 6) ? 4'b1000 : 4'b0000, k == 11);
            if (k <= 5) checkOutput("s5_held", 32'(req), 32'd0);
            if (k == 6) checkOutput("s5_release", 32'(client_grant), 32'h8);
            if (k == 11) begin
                checkOutput("s5_dv", 32'(done_valid), 32'd1);
                checkOutput("s5_id", 32'(done_id), 32'd3);
            end
        end

        // Reset two cycles after req; the late ack is masked.
        resetDut();
        for (int k = 0; k <= 9; k++) begin
            applyStimulus(k == 3, 0,
                          (k == 0) ? 4'b0100 : ((k == 6) ? 4'b0001 : 4'b0000), k == 5);
            if (k == 3) begin
                checkOutput("s6_busy", 32'(busy), 32'd0);
                checkOutput("s6_count", 32'(reqs_issued), 32'd0);
            end
            if (k == 5) begin
                checkOutput("s6_dv", 32'(done_valid), 32'd0);
                checkOutput("s6_spur", 32'(err_spurious_ack), 32'd0);
            end
            if (k == 6) checkOutput("s6_grant", 32'(client_grant), 32'h1);
        end

        // Long continuous demand so reqs_issued wraps.
        resetDut();
        for (int k = 0; k < 2100; k++) applyStimulus(0, 0, 4'hF, ackDue());

        // Randomized traffic.
        resetDut();
        cur = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (cur[i]) begin
                    if (e_grant[i] && $urandom_range(0, 3) != 0) cur[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cur[i] = 1'b1;
                end
            end
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 7) == 0,
                          cur,
                          ackDue() ? ($urandom_range(0, 99) < 85)
                                   : ($urandom_range(0, 99) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
